// File: rtl/fb_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_arbiter_pkg
// Brief    : Shared types and constants for the frame-buffer write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fb_write_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        CLEAR = 2'd2
    } arb_state_e;

    // Value written to every word by the screen-clear engine
    localparam logic [15:0] CLEAR_DATA = 16'h0000;

    // Requester indices
    localparam int REQ_BLUE = 0;
    localparam int REQ_RED  = 1;

    // Width of an index into a vector of n requesters (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : fb_write_arbiter_pkg
`default_nettype wire

// File: rtl/fb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_arbiter_if
// Brief    : Burst-writer request bundle between trail writers and arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface fb_write_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;

    // Requester side: drives the burst, watches its grant
    modport master (
        output req, req_last, req_addr, req_data,
        input  gnt
    );

    // Arbiter side
    modport slave (
        input  req, req_last, req_addr, req_data,
        output gnt
    );
endinterface : fb_write_arbiter_if
`default_nettype wire

// File: rtl/fb_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_arbiter_rr_pick
// Brief    : Combinational round-robin picker: first requester at or after
//            the pointer (wrapping), returned one-hot and as an index.
// Revision : 1.0 - initial release
// ============================================================================
module fb_write_arbiter_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  wire logic [NUM_REQ-1:0] req_i,
    input  wire logic [PTR_W-1:0]   ptr_i,
    output logic      [NUM_REQ-1:0] gnt_o,
    output logic      [PTR_W-1:0]   idx_o,
    output logic                    valid_o
);

    // Scan requesters starting at the pointer; first hit wins
    always_comb begin
        int idx;
        idx     = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!valid_o && req_i[idx]) begin
                valid_o    = 1'b1;
                gnt_o[idx] = 1'b1;
                idx_o      = PTR_W'(idx);
            end
        end
    end

endmodule : fb_write_arbiter_rr_pick
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_arbiter
// Brief    : Owns the frame-buffer write port. Round-robin burst grants to
//            the trail writers plus a built-in full-screen clear engine that
//            takes the port at the next arbitration point.
// Revision : 1.0 - initial release
// ============================================================================
module fb_write_arbiter
    import fb_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int FB_WORDS  = 76800,
    parameter int MAX_BURST = 64
) (
    input  wire logic              Clk,
    input  wire logic              Reset,
    input  wire logic              wr_window_i,
    input  wire logic              clear_start_i,
    fb_write_arbiter_if.slave      bus,
    output logic                   clear_busy_o,
    output logic                   clear_done_o,
    output logic                   fb_we_o,
    output logic [ADDR_W-1:0]      fb_addr_o,
    output logic [DATA_W-1:0]      fb_data_o
);

    localparam int PTR_W  = idx_width(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0]   fb_data_q, fb_data_d;
    logic                clear_busy_q, clear_busy_d;
    logic                clear_done_q, clear_done_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_valid;

    logic                own_req, own_last, own_gnt;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_data;
    logic                clear_req, beat, burst_end, clr_last;

    fb_write_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Select the current burst owner's request signals
    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_gnt  = 1'b0;
        own_addr = '0;
        own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == PTR_W'(i)) begin
                own_req  = bus.req[i];
                own_last = bus.req_last[i];
                own_gnt  = gnt_q[i];
                own_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                own_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A clear_start seen in IDLE beats a same-cycle request
    assign clear_req = clear_busy_q | clear_start_i;
    assign beat      = own_req & own_gnt;
    // Burst ends on last beat, on the MAX_BURST-th beat, or when req is dropped
    assign burst_end = (beat && (own_last || (beat_cnt_q == BEAT_W'(MAX_BURST - 1))))
                     || (own_gnt && !own_req);
    assign clr_last  = (clr_addr_q == ADDR_W'(FB_WORDS - 1));

    // State and datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            beat_cnt_q   <= '0;
            clr_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            beat_cnt_q   <= beat_cnt_d;
            clr_addr_q   <= clr_addr_d;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear_req)
                    state_d = CLEAR;
                else if (wr_window_i && pick_valid)
                    state_d = BURST;
            end
            BURST: if (burst_end) state_d = IDLE;
            CLEAR: if (clr_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of grant, write port, counters and clear status
    always_comb begin
        gnt_d        = gnt_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        clear_busy_d = clear_busy_q | clear_start_i;
        clear_done_d = 1'b0;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        beat_cnt_d   = beat_cnt_q;
        clr_addr_d   = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    gnt_d      = '0;
                    clr_addr_d = '0;
                end else if (wr_window_i && pick_valid) begin
                    gnt_d      = pick_gnt;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (beat) begin
                    fb_we_d    = 1'b1;
                    fb_addr_d  = own_addr;
                    fb_data_d  = own_data;
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                end
                if (burst_end) begin
                    gnt_d    = '0;
                    rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
                end
            end
            CLEAR: begin
                fb_we_d    = 1'b1;
                fb_addr_d  = clr_addr_q;
                fb_data_d  = DATA_W'(CLEAR_DATA);
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_last) begin
                    clear_done_d = 1'b1;
                    clear_busy_d = 1'b0;
                end
            end
            default: gnt_d = '0;
        endcase
    end

    assign bus.gnt      = gnt_q;
    assign fb_we_o      = fb_we_q;
    assign fb_addr_o    = fb_addr_q;
    assign fb_data_o    = fb_data_q;
    assign clear_busy_o = clear_busy_q;
    assign clear_done_o = clear_done_q;

endmodule : fb_write_arbiter
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_write_arbiter
// Brief    : Self-checking bench for fb_write_arbiter (FB_WORDS=16,
//            MAX_BURST=4) with a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_write_arbiter;
    import fb_write_arbiter_pkg::*;

    localparam int NR  = 2;
    localparam int AW  = 20;
    localparam int DW  = 16;
    localparam int FBW = 16;
    localparam int MB  = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          wr_window;
    logic          clear_start;
    logic          clear_busy, clear_done, fb_we;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_data;

    fb_write_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    fb_write_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .FB_WORDS(FBW), .MAX_BURST(MB)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .wr_window_i   (wr_window),
        .clear_start_i (clear_start),
        .bus           (bus),
        .clear_busy_o  (clear_busy),
        .clear_done_o  (clear_done),
        .fb_we_o       (fb_we),
        .fb_addr_o     (fb_addr),
        .fb_data_o     (fb_data)
    );

    always #10 Clk = ~Clk;

    int            vectors = 0;
    int            errors  = 0;
    // requester model: beats left in current burst, extra bursts queued
    int            rem[NR];
    int            pend_bursts[NR];
    int            pend_len[NR];
    logic [AW-1:0] nxt_addr[NR];
    // arbiter model
    int            gbeats[NR];
    int            last_owner;
    bit            clr_exp;
    int            clr_cnt;
    int            done_cnt;
    int            wr_cnt[NR];
    int            grant_log[$];
    int            seg_log[$];

    function automatic logic [DW-1:0] dfn(input int i, input logic [AW-1:0] a);
        logic [DW-1:0] k;
        k = (i == REQ_BLUE) ? 16'h5A5A : 16'hC3C3;
        return a[DW-1:0] ^ k;
    endfunction

    // Round-robin expectation: first requester after the last owner
    function automatic int rr_expect(input logic [NR-1:0] r);
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (last_owner + 1 + k) % NR;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            bus.req[i]                = (rem[i] > 0);
            bus.req_last[i]           = (rem[i] == 1);
            bus.req_addr[i*AW +: AW]  = nxt_addr[i];
            bus.req_data[i*DW +: DW]  = dfn(i, nxt_addr[i]);
        end
    endtask

    task automatic start_burst(input int i, input int addr, input int len, input int count);
        nxt_addr[i]    = AW'(addr);
        rem[i]         = len;
        pend_len[i]    = len;
        pend_bursts[i] = count - 1;
        drive_inputs();
    endtask

    task automatic abandon(input int i);
        rem[i]         = 0;
        pend_bursts[i] = 0;
        drive_inputs();
    endtask

    task automatic clear_logs();
        grant_log.delete();
        seg_log.delete();
        for (int i = 0; i < NR; i++) wr_cnt[i] = 0;
        done_cnt = 0;
    endtask

    // One clock: snapshot inputs, advance, check outputs against the model
    task automatic tick();
        logic [NR-1:0] beat, endx, rq, gq;
        logic [AW-1:0] ea[NR];
        logic          win, cs;
        bit            clr_pend_prev, clr_old, done_now;
        int            bi, pk;
        rq = bus.req; gq = bus.gnt; win = wr_window; cs = clear_start;
        clr_old = clr_exp;
        clr_pend_prev = clr_exp | cs;
        bi = -1;
        for (int i = 0; i < NR; i++) begin
            beat[i] = rq[i] & gq[i];
            endx[i] = (beat[i] && (bus.req_last[i] || (gbeats[i] + 1 == MB))) || (gq[i] && !rq[i]);
            ea[i]   = nxt_addr[i];
            if (beat[i] && bi < 0) bi = i;
        end
        @(posedge Clk); #1;
        done_now = 1'b0;
        vectors++;
        if (bi >= 0) begin
            if (fb_we !== 1'b1 || fb_addr !== ea[bi] || fb_data !== dfn(bi, ea[bi])) begin
                errors++;
                $display("FAIL burst_write req%0d: got we=%b addr=%0d data=%h, expected we=1 addr=%0d data=%h",
                         bi, fb_we, fb_addr, fb_data, ea[bi], dfn(bi, ea[bi]));
            end
            wr_cnt[bi]++;
        end else if (fb_we === 1'b1 && clr_old) begin
            if (fb_addr !== AW'(clr_cnt) || fb_data !== '0 || bus.gnt !== '0) begin
                errors++;
                $display("FAIL clear_write: got addr=%0d data=%h gnt=%b, expected addr=%0d data=0000 gnt=00",
                         fb_addr, fb_data, bus.gnt, clr_cnt);
            end
            clr_cnt++;
            if (clr_cnt == FBW) begin
                done_now = 1'b1; clr_exp = 1'b0; clr_cnt = 0; done_cnt++;
            end
        end else if (fb_we !== 1'b0 || clr_cnt > 0) begin
            errors++;
            $display("FAIL write_enable: got we=%b, expected %0d (clear writes done=%0d)",
                     fb_we, (clr_cnt > 0), clr_cnt);
        end
        if (cs && !clr_old) clr_exp = 1'b1;
        vectors++;
        if (clear_done !== done_now) begin
            errors++;
            $display("FAIL clear_done: got %b, expected %b", clear_done, done_now);
        end
        vectors++;
        if (clear_busy !== clr_exp) begin
            errors++;
            $display("FAIL clear_busy: got %b, expected %b", clear_busy, clr_exp);
        end
        vectors++;
        if ($countones(bus.gnt) > 1) begin
            errors++;
            $display("FAIL gnt_onehot: got %b, expected at most one bit", bus.gnt);
        end
        for (int i = 0; i < NR; i++) begin
            if (gq[i]) begin
                vectors++;
                if (bus.gnt[i] !== !endx[i]) begin
                    errors++;
                    $display("FAIL grant_hold req%0d: got gnt=%b, expected %b", i, bus.gnt[i], !endx[i]);
                end
                if (endx[i]) begin
                    last_owner = i;
                    seg_log.push_back(gbeats[i] + int'(beat[i]));
                end
            end else if (bus.gnt[i] === 1'b1) begin
                pk = rr_expect(rq);
                vectors++;
                if (gq !== '0 || !win || !rq[i] || clr_pend_prev || pk != i) begin
                    errors++;
                    $display("FAIL grant_rise: got gnt to req%0d, expected rr pick %0d (win=%b req=%b clear=%b)",
                             i, pk, win, rq, clr_pend_prev);
                end
                grant_log.push_back(i);
                gbeats[i] = 0;
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (beat[i]) begin
                gbeats[i]++;
                nxt_addr[i] = nxt_addr[i] + AW'(1);
                rem[i]--;
                if (rem[i] == 0 && pend_bursts[i] > 0) begin
                    rem[i] = pend_len[i];
                    pend_bursts[i]--;
                end
            end
        end
        drive_inputs();
    endtask

    task automatic pulse_clear();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while ((rem[0] > 0 || rem[1] > 0 || clr_exp || bus.gnt !== '0) && n < budget) begin
            tick();
            n++;
        end
        tick();
        vectors++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: got still busy after %0d cycles, expected idle", tag, n);
        end
    endtask

    task automatic wait_gnt(input int i, input int beats, input int budget);
        int n;
        n = 0;
        while (!(bus.gnt[i] === 1'b1 && gbeats[i] >= beats) && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_gnt req%0d: got no grant with %0d beats, expected one within %0d cycles",
                     i, beats, budget);
        end
    endtask

    task automatic do_reset();
        Reset       = 1'b1;
        clear_start = 1'b0;
        for (int i = 0; i < NR; i++) begin rem[i] = 0; pend_bursts[i] = 0; end
        drive_inputs();
        repeat (2) @(posedge Clk);
        #1;
        vectors++;
        if (bus.gnt !== '0 || fb_we !== 1'b0 || fb_addr !== '0 || fb_data !== '0 ||
            clear_busy !== 1'b0 || clear_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got gnt=%b we=%b addr=%0d data=%h busy=%b done=%b, expected all 0",
                     bus.gnt, fb_we, fb_addr, fb_data, clear_busy, clear_done);
        end
        Reset      = 1'b0;
        clr_exp    = 1'b0;
        clr_cnt    = 0;
        last_owner = NR - 1;
        for (int i = 0; i < NR; i++) gbeats[i] = 0;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) tick();
    endtask

    task automatic test_single_burst();
        wr_window = 1'b1;
        clear_logs();
        start_burst(REQ_BLUE, 100, 3, 1);
        wait_idle(40, "single");
        vectors++;
        if (wr_cnt[0] != 3 || seg_log.size() != 1 || (seg_log.size() == 1 && seg_log[0] != 3)) begin
            errors++;
            $display("FAIL single_burst: got %0d writes in %0d grants, expected 3 writes in 1 grant",
                     wr_cnt[0], seg_log.size());
        end
    endtask

    task automatic test_contention();
        int exp_log[6];
        exp_log = '{0, 1, 0, 1, 0, 1};
        do_reset();
        wr_window = 1'b1;
        start_burst(REQ_BLUE, 200, 2, 3);
        start_burst(REQ_RED, 300, 2, 3);
        wait_idle(100, "contention");
        vectors++;
        if (grant_log.size() != 6) begin
            errors++;
            $display("FAIL contention_count: got %0d grants, expected 6", grant_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                vectors++;
                if (grant_log[k] != exp_log[k]) begin
                    errors++;
                    $display("FAIL contention_order[%0d]: got req%0d, expected req%0d", k, grant_log[k], exp_log[k]);
                end
            end
        end
    endtask

    task automatic test_forced_release();
        clear_logs();
        start_burst(REQ_RED, 500, 6, 1);
        wait_idle(60, "forced");
        vectors++;
        if (wr_cnt[1] != 6 || seg_log.size() != 2 ||
            (seg_log.size() == 2 && (seg_log[0] != MB || seg_log[1] != 2))) begin
            errors++;
            $display("FAIL forced_release: got %0d writes in %0d grants, expected 6 writes split 4+2",
                     wr_cnt[1], seg_log.size());
        end
    endtask

    task automatic test_clear_during_burst();
        clear_logs();
        start_burst(REQ_BLUE, 600, 3, 1);
        wait_gnt(REQ_BLUE, 1, 20);
        pulse_clear();
        start_burst(REQ_RED, 700, 2, 1);
        wait_idle(100, "clear_burst");
        vectors++;
        if (done_cnt != 1 || wr_cnt[0] != 3 || wr_cnt[1] != 2 || grant_log.size() != 2 ||
            (grant_log.size() == 2 && (grant_log[0] != 0 || grant_log[1] != 1))) begin
            errors++;
            $display("FAIL clear_during_burst: got done=%0d writes=%0d/%0d grants=%0d, expected 1, 3/2, 2",
                     done_cnt, wr_cnt[0], wr_cnt[1], grant_log.size());
        end
    endtask

    task automatic test_window_abandon();
        clear_logs();
        wr_window = 1'b0;
        start_burst(REQ_BLUE, 800, 6, 1);
        repeat (10) tick();
        vectors++;
        if (grant_log.size() != 0 || bus.gnt !== '0) begin
            errors++;
            $display("FAIL window_block: got %0d grants gnt=%b, expected none", grant_log.size(), bus.gnt);
        end
        wr_window = 1'b1;
        wait_gnt(REQ_BLUE, 2, 20);
        abandon(REQ_BLUE);
        wait_idle(20, "abandon");
        vectors++;
        if (wr_cnt[0] != 2) begin
            errors++;
            $display("FAIL abandon: got %0d writes, expected 2", wr_cnt[0]);
        end
        start_burst(REQ_RED, 900, 3, 1);
        wait_gnt(REQ_RED, 0, 20);
        wr_window = 1'b0;
        wait_idle(20, "window_drop");
        vectors++;
        if (wr_cnt[1] != 3) begin
            errors++;
            $display("FAIL window_drop: got %0d writes, expected 3", wr_cnt[1]);
        end
        wr_window = 1'b1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < NR; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 1) == 1)
                    start_burst(i, int'($urandom_range(0, 20'hFFFF0)), int'($urandom_range(1, 7)), 1);
                else if (rem[i] > 0 && $urandom_range(0, 31) == 0)
                    abandon(i);
            end
            wr_window = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) pulse_clear();
            repeat ($urandom_range(1, 5)) tick();
        end
        wr_window = 1'b1;
        wait_idle(300, "random");
    endtask

    task automatic test_reset_mid_clear();
        int n;
        pulse_clear();
        n = 0;
        while (clr_cnt < 8 && n < 40) begin tick(); n++; end
        vectors++;
        if (clr_cnt < 8) begin
            errors++;
            $display("FAIL reset_mid_clear_reach: got %0d clear writes, expected 8", clr_cnt);
        end
        do_reset();
        repeat (10) tick();
    endtask

    initial begin
        Reset       = 1'b1;
        wr_window   = 1'b0;
        clear_start = 1'b0;
        last_owner  = NR - 1;
        clr_exp     = 1'b0;
        clr_cnt     = 0;
        for (int i = 0; i < NR; i++) begin
            rem[i] = 0; pend_bursts[i] = 0; pend_len[i] = 0; nxt_addr[i] = '0; gbeats[i] = 0;
        end
        clear_logs();
        drive_inputs();
        test_reset();
        test_single_burst();
        test_contention();
        test_forced_release();
        test_clear_during_burst();
        test_window_abandon();
        test_random();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_fb_write_arbiter
`default_nettype wire
